alsu_cmd_issuer: RTL and testbench



---
 rtl/alsu_cmd_issuer.sv | 103 ++++++++++
 tb/tb_alsu_cmd_issuer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_issuer.sv
// ALSU command issuer: buffers packed commands in a FIFO and
// issues them one at a time with a programmable idle gap.
module alsu_cmd_issuer #(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [14:0]              cmd_data,
    input  logic                     hold,
    output logic [2:0]               A,
    output logic [2:0]               B,
    output logic [2:0]               opcode,
    output logic                     cin,
    output logic                     serial_in,
    output logic                     red_op_A,
    output logic                     red_op_B,
    output logic                     bypass_A,
    output logic                     bypass_B,
    output logic                     issue_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               illegal_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(ISSUE_GAP + 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GAP  = 1'b1;

    logic [14:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [0:0]    state;
    logic [GW-1:0] gap_cnt;
    logic          push;
    logic          pop;
    logic          bad;
    logic [14:0]   head;

    assign cmd_ready = (fifo_count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0) && !hold;
    assign head      = mem[rptr];

    // opcode 6/7, or a reduction request on anything but AND/XOR
    assign bad = (head[8:7] == 2'b11) ||
                 ((head[11] | head[12]) && (head[8:7] != 2'b00));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            fifo_count  <= '0;
            state       <= IDLE;
            gap_cnt     <= '0;
            issue_valid <= 1'b0;
            illegal_cnt <= '0;
            {bypass_B, bypass_A, red_op_B, red_op_A,
             serial_in, cin, opcode, B, A} <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            issue_valid <= pop;
            if (pop) begin
                {bypass_B, bypass_A, red_op_B, red_op_A,
                 serial_in, cin, opcode, B, A} <= head;
                if (bad && (illegal_cnt != 8'hFF)) begin
                    illegal_cnt <= illegal_cnt + 8'd1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (pop && (ISSUE_GAP > 0)) begin
                        gap_cnt <= GW'(ISSUE_GAP);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Randomized and directed bench for alsu_cmd_issuer against a
// queue-based reference model.
module tb_alsu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int GAPC  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_data;
    logic        hold;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B;
    logic        issue_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]  illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    alsu_cmd_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(GAPC)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .hold(hold), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .red_op_A(red_op_A),
        .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .issue_valid(issue_valid), .fifo_count(fifo_count),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    wire [14:0] outs = {bypass_B, bypass_A, red_op_B, red_op_A,
                        serial_in, cin, opcode, B, A};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_illegal(input logic [14:0] c);
        int op;
        op = int'(c[8:6]);
        return (op >= 6) || ((c[11] || c[12]) && op > 1);
    endfunction

    // Reference model: a queue, the last issued word and the
    // number of edges since the last issue.
    logic [14:0] mq[$];
    logic [14:0] m_out = '0;
    bit          m_iv = 0;
    int          m_ill = 0;
    int          since = 1000;
    bit          armed = 0;

    always @(posedge clk) begin
        bit pu, po;
        if (rst) begin
            mq.delete();
            m_out = '0;
            m_iv  = 0;
            m_ill = 0;
            since = 1000;
            armed = 1;
        end else begin
            pu = cmd_valid && (mq.size() != DEPTH);
            po = (mq.size() != 0) && !hold && (since > GAPC);
            m_iv = po;
            if (po) begin
                m_out = mq.pop_front();
                since = 1;
                if (is_illegal(m_out) && m_ill < 255) m_ill++;
            end else if (since < 1000) begin
                since++;
            end
            if (pu) mq.push_back(cmd_data);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("m_cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
            chk("m_outputs", 32'(outs), 32'(m_out));
            chk("m_issue_valid", 32'(issue_valid), 32'(m_iv));
            chk("m_illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          tc[$];
        logic [2:0]  ta[$];
        logic [14:0] ic[3];
        int          iop[3];
        int          iexp[3];
        int          k;

        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_data = 15'h7fff;
        hold = 1'b0;

        // 1: reset with cmd_valid asserted
        repeat (3) step();
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_outs", 32'(outs), 0);
        chk("rst_iv", 32'(issue_valid), 0);
        chk("rst_ill", 32'(illegal_cnt), 0);

        // 2: single command, one-cycle latency
        cmd_data = {6'b0, 3'd2, 3'd3, 3'd5};
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("one_count_after_push", 32'(fifo_count), 1);
        chk("one_no_bypass", 32'(issue_valid), 0);
        step();
        @(negedge clk);
        chk("one_A", 32'(A), 5);
        chk("one_B", 32'(B), 3);
        chk("one_op", 32'(opcode), 2);
        chk("one_iv", 32'(issue_valid), 1);
        chk("one_count_empty", 32'(fifo_count), 0);
        step();
        @(negedge clk);
        chk("one_iv_drop", 32'(issue_valid), 0);
        chk("one_hold_A", 32'(A), 5);

        // 3: fill under hold, then drain with gap spacing
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_data = {6'b0, 3'd0, 3'(i), 3'(i + 1)};
            cmd_valid = 1'b1;
            step();
            if (i == 3) chk("full_ready_low", 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("full_count", 32'(fifo_count), 4);
        hold = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            @(negedge clk);
            if (issue_valid) begin
                tc.push_back(c);
                ta.push_back(A);
            end
        end
        chk("drain_pulses", 32'(tc.size()), 4);
        for (int i = 0; i < 4 && i < tc.size(); i++) begin
            chk("drain_order", 32'(ta[i]), 32'(i + 1));
            chk("drain_spacing", 32'(tc[i] - tc[0]), 32'(2 * i));
        end
        chk("drain_empty", 32'(fifo_count), 0);

        // 4: hold with two entries queued
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_data = {6'b0, 3'd0, 3'd1, 3'(6 + i)};
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk("hold_no_iv", 32'(issue_valid), 0);
            chk("hold_outs", 32'(outs), 32'({6'b0, 3'd0, 3'd3, 3'd4}));
        end
        hold = 1'b0;
        step();
        @(negedge clk);
        chk("hold_release_iv", 32'(issue_valid), 1);
        chk("hold_release_A", 32'(A), 6);
        repeat (4) step();

        // 5: illegal command counting
        ic[0] = {6'b000000, 3'd7, 3'd1, 3'd1};
        ic[1] = {6'b000100, 3'd3, 3'd2, 3'd2};
        ic[2] = {6'b001000, 3'd1, 3'd3, 3'd3};
        iop = '{7, 3, 1};
        iexp = '{1, 2, 2};
        @(negedge clk);
        chk("ill_start", 32'(illegal_cnt), 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_data = ic[i];
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        hold = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            @(negedge clk);
            if (issue_valid && k < 3) begin
                chk("ill_op", 32'(opcode), 32'(iop[k]));
                chk("ill_A", 32'(A), 32'(k + 1));
                chk("ill_cnt", 32'(illegal_cnt), 32'(iexp[k]));
                k++;
            end
        end
        chk("ill_issued", 32'(k), 3);

        // 6: reset while in the gap with three entries queued
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_data = {6'b0, 3'd0, 3'd2, 3'(i)};
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        hold = 1'b0;
        step();
        chk("gap_count_before_rst", 32'(fifo_count), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("gap_rst_count", 32'(fifo_count), 0);
        chk("gap_rst_outs", 32'(outs), 0);
        chk("gap_rst_ill", 32'(illegal_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            chk("gap_rst_quiet", 32'(issue_valid), 0);
        end

        // random traffic; late phase has no reset so illegal_cnt saturates
        for (int n = 0; n < 1500; n++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_data = 15'($urandom);
            hold = ($urandom_range(0, 7) == 0);
            rst = (n < 300) && ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        hold = 1'b0;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
